// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable frame format, majority voting and error flags
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 clken,
    input  logic                 Rx,
    input  logic                 ready_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 new_data_av,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] C_LO   = CW'(M - 1);
    localparam logic [CW-1:0] C_MID  = CW'(M);
    localparam logic [CW-1:0] C_VOTE = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic                 rx_meta, rxs;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic                 s_lo, s_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, fe_acc;
    logic                 vote, exp_par, done;

    // two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) {rx_meta, rxs} <= 2'b11;
        else     {rx_meta, rxs} <= {Rx, rx_meta};
    end

    // majority of the three mid-bit samples, expected parity, and the frame-complete strobe
    always_comb begin
        vote    = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
        exp_par = (^shreg) ^ (PARITY == 1);
        done    = clken && state == S_STOP && cnt == C_VOTE && stop_idx == S_LAST;
    end

    // capture the two samples that precede the vote count
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            s_lo  <= 1'b0;
            s_mid <= 1'b0;
        end else begin
            if (clken && cnt == C_LO)  s_lo  <= rxs;
            if (clken && cnt == C_MID) s_mid <= rxs;
        end
    end

    // frame state machine, advancing only on oversample enables
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            fe_acc   <= 1'b0;
        end else if (clken) begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state    <= S_START;
                        cnt      <= CW'(1);
                        idx      <= '0;
                        stop_idx <= 1'b0;
                        par_bad  <= 1'b0;
                        fe_acc   <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt == C_VOTE && vote) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == C_LAST) begin
                        state <= S_DATA;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == C_VOTE) shreg[idx] <= vote;
                    if (cnt == C_LAST) begin
                        cnt <= '0;
                        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
                        if (idx == I_LAST) state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (cnt == C_VOTE) par_bad <= vote ^ exp_par;
                    if (cnt == C_LAST) begin
                        state <= S_STOP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == C_VOTE && !vote) fe_acc <= 1'b1;
                    if (cnt == C_VOTE && stop_idx == S_LAST) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        stop_idx <= 1'b0;
                    end else if (cnt == C_LAST) begin
                        cnt      <= '0;
                        stop_idx <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // deliver the word and flags on completion; completion beats a simultaneous ready_clr
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            data        <= '0;
            ready       <= 1'b0;
            new_data_av <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            new_data_av <= done;
            if (done) begin
                data       <= shreg;
                parity_err <= (PARITY != 0) && par_bad;
                frame_err  <= fe_acc | ~vote;
            end
            ready   <= done | (ready & ~ready_clr);
            overrun <= ~ready_clr & (overrun | (done & ready));
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: random and directed frames into three receiver configurations, scoreboard-checked
module tb_uart_rx_param;
    localparam int BITCLK = 64;

    typedef struct {
        int         k;
        logic [8:0] d;
        logic       pe, fe, ov;
    } exp_t;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic       clken   = 1'b0;
    logic [2:0] rx      = 3'b111;
    logic [2:0] clr     = 3'b000;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic [2:0] rdy, nda, pe, fe, ov;
    logic [2:0] nda_prev = 3'b000;
    logic [2:0] rdy_m = 3'b000, ovr_m = 3'b000, pe_m = 3'b000, fe_m = 3'b000;
    int         db[3] = '{8, 8, 9};
    int         pm[3] = '{0, 2, 1};
    int         sb[3] = '{1, 1, 2};
    int         vectors = 0, miscompares = 0;
    exp_t       q[$];
    exp_t       mon_e;

    uart_rx_param u0 (
        .clk_50m(clk_50m), .rst(rst), .clken(clken), .Rx(rx[0]), .ready_clr(clr[0]),
        .data(d0), .ready(rdy[0]), .new_data_av(nda[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .overrun(ov[0])
    );
    uart_rx_param #(.PARITY(2)) u1 (
        .clk_50m(clk_50m), .rst(rst), .clken(clken), .Rx(rx[1]), .ready_clr(clr[1]),
        .data(d1), .ready(rdy[1]), .new_data_av(nda[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .overrun(ov[1])
    );
    uart_rx_param #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk_50m(clk_50m), .rst(rst), .clken(clken), .Rx(rx[2]), .ready_clr(clr[2]),
        .data(d2), .ready(rdy[2]), .new_data_av(nda[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .overrun(ov[2])
    );

    initial forever #10 clk_50m = ~clk_50m;

    initial forever begin
        repeat (3) @(negedge clk_50m);
        clken = 1'b1;
        @(negedge clk_50m);
        clken = 1'b0;
    end

    initial begin
        #1800000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] dout(input int k);
        return (k == 0) ? {1'b0, d0} : (k == 1) ? {1'b0, d1} : d2;
    endfunction

    task automatic chk(input string name, input int k, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    // monitor: every completion pulse pops the oldest expectation
    always @(negedge clk_50m) begin
        for (int k = 0; k < 3; k++) begin
            if (nda[k]) begin
                chk("nda_width", k, 9'(nda_prev[k]), 9'd0);
                if (q.size() == 0 || q[0].k != k) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame dut%0d: got data %h expected no frame", k, dout(k));
                end else begin
                    mon_e = q.pop_front();
                    chk("data", k, dout(k), mon_e.d);
                    chk("parity_err", k, 9'(pe[k]), 9'(mon_e.pe));
                    chk("frame_err", k, 9'(fe[k]), 9'(mon_e.fe));
                    chk("overrun", k, 9'(ov[k]), 9'(mon_e.ov));
                    chk("ready", k, 9'(rdy[k]), 9'd1);
                end
            end
        end
        nda_prev <= nda;
    end

    task automatic drive_bit(input int k, input logic v);
        rx[k] = v;
        repeat (BITCLK) begin
            @(negedge clk_50m);
            if (nda[k]) clr[k] = 1'b0;
        end
    endtask

    task automatic send(input int k, input logic [8:0] d, input bit bad_par,
                        input logic [1:0] stops, input bit clr_done);
        logic [8:0] m;
        logic       p;
        exp_t       e;
        m    = d & ((9'd1 << db[k]) - 9'd1);
        p    = (^m) ^ (pm[k] == 1) ^ bad_par;
        e.k  = k;
        e.d  = m;
        e.pe = (pm[k] != 0) && bad_par;
        e.fe = !stops[0] || (sb[k] == 2 && !stops[1]);
        e.ov = !clr_done && (ovr_m[k] || rdy_m[k]);
        q.push_back(e);
        rdy_m[k] = 1'b1;
        ovr_m[k] = e.ov;
        pe_m[k]  = e.pe;
        fe_m[k]  = e.fe;
        drive_bit(k, 1'b0);
        for (int i = 0; i < db[k]; i++) drive_bit(k, m[i]);
        if (pm[k] != 0) drive_bit(k, p);
        if (clr_done) clr[k] = 1'b1;
        for (int i = 0; i < sb[k]; i++) drive_bit(k, stops[i]);
        drive_bit(k, 1'b1);
        if (clr[k]) begin
            clr[k] = 1'b0;
            vectors++;
            miscompares++;
            $display("FAIL completion_timeout dut%0d: got no new_data_av expected one", k);
        end
    endtask

    task automatic pulse_clr(input int k);
        clr[k] = 1'b1;
        @(negedge clk_50m);
        clr[k]   = 1'b0;
        rdy_m[k] = 1'b0;
        ovr_m[k] = 1'b0;
        chk("ready_after_clr", k, 9'(rdy[k]), 9'd0);
        chk("overrun_after_clr", k, 9'(ov[k]), 9'd0);
        chk("parity_err_kept", k, 9'(pe[k]), 9'(pe_m[k]));
        chk("frame_err_kept", k, 9'(fe[k]), 9'(fe_m[k]));
    endtask

    task automatic chk_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            chk("rst_data", k, dout(k), 9'd0);
            chk("rst_ready", k, 9'(rdy[k]), 9'd0);
            chk("rst_nda", k, 9'(nda[k]), 9'd0);
            chk("rst_flags", k, {6'd0, pe[k], fe[k], ov[k]}, 9'd0);
        end
    endtask

    initial begin : main
        int         k;
        logic [8:0] d;
        bit         bp, cd;
        logic [1:0] st;
        repeat (5) @(negedge clk_50m);
        chk_reset_outputs();
        rst = 1'b0;
        repeat (BITCLK) @(negedge clk_50m);
        send(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
        pulse_clr(0);
        rx[0] = 1'b0;
        repeat (12) @(negedge clk_50m);
        rx[0] = 1'b1;
        repeat (2 * BITCLK) @(negedge clk_50m);
        chk("false_start_ready", 0, 9'(rdy[0]), 9'd0);
        send(0, 9'h03C, 1'b0, 2'b11, 1'b0);
        send(1, 9'h003, 1'b1, 2'b11, 1'b0);
        send(1, 9'h003, 1'b0, 2'b11, 1'b0);
        pulse_clr(0);
        send(0, 9'h055, 1'b0, 2'b10, 1'b0);
        send(0, 9'h05A, 1'b0, 2'b11, 1'b0);
        pulse_clr(0);
        send(0, 9'h011, 1'b0, 2'b11, 1'b0);
        send(0, 9'h022, 1'b0, 2'b11, 1'b0);
        pulse_clr(0);
        send(0, 9'h033, 1'b0, 2'b11, 1'b0);
        send(0, 9'h044, 1'b0, 2'b11, 1'b1);
        chk("ready_kept_clr_at_done", 0, 9'(rdy[0]), 9'd1);
        rx[2] = 1'b0;
        repeat (BITCLK) @(negedge clk_50m);
        for (int i = 0; i < 4; i++) begin
            rx[2] = (i == 1) ? 1'b0 : 1'b1;
            repeat (BITCLK) @(negedge clk_50m);
        end
        rx[2] = 1'b0;
        repeat (BITCLK / 2) @(negedge clk_50m);
        rst = 1'b1;
        @(negedge clk_50m);
        chk_reset_outputs();
        rx[2] = 1'b1;
        rdy_m = 3'b000;
        ovr_m = 3'b000;
        pe_m  = 3'b000;
        fe_m  = 3'b000;
        repeat (4) @(negedge clk_50m);
        rst = 1'b0;
        repeat (BITCLK) @(negedge clk_50m);
        send(2, 9'h1FF, 1'b0, 2'b11, 1'b0);
        for (int n = 0; n < 24; n++) begin
            k  = int'($urandom_range(0, 2));
            d  = 9'($urandom);
            bp = (pm[k] != 0) && ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            cd = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 2) == 0) pulse_clr(k);
            send(k, d, bp, st, cd);
        end
        repeat (2 * BITCLK) @(negedge clk_50m);
        chk("pending_frames", 0, 9'(q.size()), 9'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
